// File: rtl/counter_pkg.sv
// Shared types for the modulo counter block.
// Latency: n/a (types only).
// Backpressure: n/a.
package counter_pkg;

    typedef enum logic {
        CNT_WRAP     = 1'b0,
        CNT_SATURATE = 1'b1
    } cnt_mode_e;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: raises tick once every PRESCALE enabled cycles.
// Latency: combinational tick from the registered prescale count.
// Backpressure: enable low freezes the prescaler; restart forces it to 0.
module tick_gen #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic restart,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    generate
        if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
            $error("tick_gen: PRESCALE must be in 1..65535");
        end
    endgenerate

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    // With PRESCALE == 1, LAST is 0 and cnt_q never leaves 0, so tick == enable.
    assign tick = enable && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = tick ? '0 : cnt_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mod_counter.sv
// Up/down modulo counter with prescaler, clear/load, wrap or saturate at bounds.
// Latency: count and tc registered (1 cycle); at_zero/at_max combinational.
// Backpressure: enable low holds count and prescaler; clear > load > step.
module mod_counter
    import counter_pkg::*;
#(
    parameter int        DATA_WIDTH = 8,
    parameter int        MAX_VALUE  = 2**DATA_WIDTH - 1,
    parameter int        PRESCALE   = 1,
    parameter cnt_mode_e MODE       = CNT_WRAP
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  up_dn,
    input  logic                  clear,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_value,
    output logic [DATA_WIDTH-1:0] count,
    output logic                  at_zero,
    output logic                  at_max,
    output logic                  tc
);

    generate
        if (MAX_VALUE < 0 || (MAX_VALUE >> DATA_WIDTH) != 0) begin : g_bad_max
            $error("mod_counter: MAX_VALUE must fit in DATA_WIDTH bits");
        end
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("mod_counter: PRESCALE must be at least 1");
        end
    endgenerate

    localparam logic [DATA_WIDTH-1:0] MAXV = DATA_WIDTH'(MAX_VALUE);

    logic [DATA_WIDTH-1:0] count_q;
    logic [DATA_WIDTH-1:0] count_d;
    logic                  tc_q;
    logic                  tc_d;
    logic                  tick;
    logic                  restart;

    assign restart = clear | load;

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .restart (restart),
        .tick    (tick)
    );

    assign count   = count_q;
    assign at_zero = (count_q == '0);
    assign at_max  = (count_q == MAXV);
    assign tc      = tc_q;

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = (load_value > MAXV) ? MAXV : load_value;
        end else if (tick) begin
            // Boundary steps never go through the adder, so a short MAX_VALUE
            // cannot be overrun.
            if (up_dn) begin
                if (at_max) begin
                    tc_d    = 1'b1;
                    count_d = (MODE == CNT_WRAP) ? '0 : count_q;
                end else begin
                    count_d = count_q + DATA_WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    tc_d    = 1'b1;
                    count_d = (MODE == CNT_WRAP) ? MAXV : count_q;
                end else begin
                    count_d = count_q - DATA_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench: three counter instances (wrap/1, saturate/1, wrap/4) on shared controls.
module tb_mod_counter;
    import counter_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       en_w, en_s, en_p;
    logic       up_dn;
    logic       clear;
    logic       load;
    logic [3:0] load_value;

    logic [3:0] count_w, count_s, count_p;
    logic       at_zero_w, at_zero_s, at_zero_p;
    logic       at_max_w, at_max_s, at_max_p;
    logic       tc_w, tc_s, tc_p;

    int checks = 0;
    int errors = 0;

    mod_counter #(.DATA_WIDTH(4), .MAX_VALUE(9), .PRESCALE(1), .MODE(CNT_WRAP)) dut_w (
        .clk(clk), .rst_n(rst_n), .enable(en_w), .up_dn(up_dn), .clear(clear),
        .load(load), .load_value(load_value), .count(count_w),
        .at_zero(at_zero_w), .at_max(at_max_w), .tc(tc_w));

    mod_counter #(.DATA_WIDTH(4), .MAX_VALUE(9), .PRESCALE(1), .MODE(CNT_SATURATE)) dut_s (
        .clk(clk), .rst_n(rst_n), .enable(en_s), .up_dn(up_dn), .clear(clear),
        .load(load), .load_value(load_value), .count(count_s),
        .at_zero(at_zero_s), .at_max(at_max_s), .tc(tc_s));

    mod_counter #(.DATA_WIDTH(4), .MAX_VALUE(9), .PRESCALE(4), .MODE(CNT_WRAP)) dut_p (
        .clk(clk), .rst_n(rst_n), .enable(en_p), .up_dn(up_dn), .clear(clear),
        .load(load), .load_value(load_value), .count(count_p),
        .at_zero(at_zero_p), .at_max(at_max_p), .tc(tc_p));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge and settle; outputs are sampled 1 time unit after posedge.
    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    int pre_exp[14];

    initial begin
        rst_n = 1'b0; en_w = 0; en_s = 0; en_p = 0;
        up_dn = 1'b1; clear = 0; load = 0; load_value = '0;

        #12;
        chk("rst_count_w", int'(count_w), 0);
        chk("rst_at_zero_w", int'(at_zero_w), 1);
        chk("rst_tc_w", int'(tc_w), 0);
        chk("rst_count_p", int'(count_p), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // Wrap, prescale 1, count up 12 cycles from 0.
        en_w = 1'b1; up_dn = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            chk($sformatf("wrap_up_count_%0d", i), int'(count_w), i % 10);
            chk($sformatf("wrap_up_tc_%0d", i), int'(tc_w), (i == 10) ? 1 : 0);
            chk($sformatf("wrap_up_max_%0d", i), int'(at_max_w), (i == 9) ? 1 : 0);
        end
        en_w = 1'b0;

        // Saturate, down from a load of 2.
        load = 1'b1; load_value = 4'd2;
        cyc();
        load = 1'b0;
        chk("sat_load2", int'(count_s), 2);
        en_s = 1'b1; up_dn = 1'b0;
        cyc(); chk("sat_dn_c1", int'(count_s), 1); chk("sat_dn_t1", int'(tc_s), 0);
        cyc(); chk("sat_dn_c2", int'(count_s), 0); chk("sat_dn_t2", int'(tc_s), 0);
        chk("sat_at_zero", int'(at_zero_s), 1);
        cyc(); chk("sat_dn_c3", int'(count_s), 0); chk("sat_dn_t3", int'(tc_s), 1);
        cyc(); chk("sat_dn_c4", int'(count_s), 0); chk("sat_dn_t4", int'(tc_s), 1);
        en_s = 1'b0;
        cyc(); chk("sat_tc_drop", int'(tc_s), 0);

        // Clear beats load; load clamps to MAX_VALUE.
        clear = 1'b1; load = 1'b1; load_value = 4'd5;
        cyc();
        clear = 1'b0; load = 1'b0;
        chk("clr_over_load", int'(count_w), 0);
        load = 1'b1; load_value = 4'd15;
        cyc();
        load = 1'b0;
        chk("load_clamp_w", int'(count_w), 9);
        chk("load_clamp_max_w", int'(at_max_w), 1);
        chk("load_clamp_max_s", int'(at_max_s), 1);

        // Prescale 4: two full windows, then a window with a 2-cycle enable gap.
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        en_p = 1'b1; up_dn = 1'b1;
        pre_exp = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 2, 2, 3};
        for (int i = 0; i < 14; i++) begin
            if (i == 10) en_p = 1'b0;
            if (i == 12) en_p = 1'b1;
            cyc();
            chk($sformatf("pre4_count_%0d", i), int'(count_p), pre_exp[i]);
        end

        // Async reset mid-prescale at count 7.
        load = 1'b1; load_value = 4'd7;
        cyc();
        load = 1'b0;
        chk("pre4_load7", int'(count_p), 7);
        chk("pre4_load7_max", int'(at_max_p), 0);
        cyc();
        cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_count", int'(count_p), 0);
        chk("async_rst_zero", int'(at_zero_p), 1);
        chk("async_rst_tc", int'(tc_p), 0);
        #2 rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk($sformatf("post_rst_count_%0d", i), int'(count_p), (i == 4) ? 1 : 0);
        end
        en_p = 1'b0;

        // Direction flip at 9 in wrap mode.
        load = 1'b1; load_value = 4'd9;
        cyc();
        load = 1'b0;
        en_w = 1'b1; up_dn = 1'b0;
        cyc(); chk("flip_dn", int'(count_w), 8); chk("flip_dn_tc", int'(tc_w), 0);
        up_dn = 1'b1;
        cyc(); chk("flip_up9", int'(count_w), 9); chk("flip_up9_tc", int'(tc_w), 0);
        cyc(); chk("flip_wrap0", int'(count_w), 0); chk("flip_wrap_tc", int'(tc_w), 1);
        en_w = 1'b0;
        cyc(); chk("flip_hold", int'(count_w), 0); chk("flip_tc_drop", int'(tc_w), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 8: bit width of count and load_value.
REQ-002 The block SHALL take parameter MAX_VALUE, default 2**DATA_WIDTH-1: terminal value; count range 0..MAX_VALUE.
REQ-003 The block SHALL take parameter PRESCALE, default 1: clock-enable cycles per count step, legal range 1..65535.
REQ-004 The block SHALL take parameter MODE, default CNT_WRAP: boundary behaviour, either CNT_WRAP or CNT_SATURATE.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port enable, input, 1 bit: advances prescaler and count when high.
REQ-008 The block SHALL have port up_dn, input, 1 bit: 1 = count up, 0 = count down.
REQ-009 The block SHALL have port clear, input, 1 bit: synchronous clear to 0.
REQ-010 The block SHALL have port load, input, 1 bit: synchronous load of load_value.
REQ-011 The block SHALL have port load_value, input, DATA_WIDTH bits: value taken on load.
REQ-012 The block SHALL have port count, output, DATA_WIDTH bits: current count, registered.
REQ-013 The block SHALL have port at_zero, output, 1 bit: combinational, count == 0.
REQ-014 The block SHALL have port at_max, output, 1 bit: combinational, count == MAX_VALUE.
REQ-015 The block SHALL have port tc, output, 1 bit: registered one-cycle terminal-count pulse.

Function
REQ-016 Per-cycle priority SHALL be: clear, then load, then step; only the highest-priority active event takes effect.
REQ-017 clear SHALL set count to 0, reset the prescaler to 0 and deassert tc on the next edge.
REQ-018 load SHALL set count to min(load_value, MAX_VALUE), reset the prescaler to 0 and deassert tc on the next edge.
REQ-019 With enable high, the prescaler SHALL count 0..PRESCALE-1 and raise an internal tick in the cycle it equals PRESCALE-1, then return to 0.
REQ-020 With PRESCALE == 1, tick SHALL equal enable.
REQ-021 With enable low, the prescaler and count SHALL hold their values.
REQ-022 A step SHALL occur on a cycle with tick high and no clear or load: count +1 if up_dn is 1, -1 if up_dn is 0.
REQ-023 In CNT_WRAP mode, an up step at MAX_VALUE SHALL give 0, and a down step at 0 SHALL give MAX_VALUE.
REQ-024 In CNT_SATURATE mode, an up step at MAX_VALUE and a down step at 0 SHALL leave count unchanged.
REQ-025 tc SHALL be high for exactly the one cycle after a step taken at a boundary (up at MAX_VALUE, or down at 0), in either mode, and low otherwise.
REQ-026 up_dn changing mid-prescale SHALL NOT reset the prescaler; the step direction SHALL be sampled in the tick cycle.
REQ-027 Arithmetic SHALL never produce a value outside 0..MAX_VALUE, including when MAX_VALUE is below 2**DATA_WIDTH-1.
REQ-028 MAX_VALUE greater than 2**DATA_WIDTH-1, or PRESCALE equal to 0, SHALL be rejected at elaboration.

Reset
REQ-029 While rst_n is low, count, the prescaler and tc SHALL be 0, and at_zero SHALL be 1, regardless of clk.
REQ-030 Reset asserted mid-prescale or mid-pulse SHALL abort it immediately; the first step after release SHALL occur PRESCALE enabled cycles later.

Structure
REQ-031 The MODE enum (CNT_WRAP, CNT_SATURATE) SHALL be defined in the shared package counter_pkg.
REQ-032 The prescaler SHALL be the sub-module tick_gen, with ports clk, rst_n, enable, restart, tick and parameter PRESCALE.
REQ-033 Total RTL SHALL be no more than 400 lines across mod_counter and tick_gen.

Verification (DATA_WIDTH=4, MAX_VALUE=9 unless noted)
REQ-034 The bench SHALL cover: CNT_WRAP, PRESCALE=1, up, enable held 12 cycles from 0 -> count 1..9,0,1,2; tc high only in the cycle after count reaches 0.
REQ-035 The bench SHALL cover: CNT_SATURATE, down from load 2 -> count 1,0,0,0; tc pulses on each step attempted at 0.
REQ-036 The bench SHALL cover: PRESCALE=4, up, enable continuous -> count increments every 4th cycle; enable low for 2 cycles mid-window stretches that window to 6 cycles.
REQ-037 The bench SHALL cover: clear and load asserted together with load_value=5 -> count=0; load alone with load_value=15 -> count=9 and at_max=1.
REQ-038 The bench SHALL cover: rst_n pulsed low asynchronously between edges at count=7 -> count=0 immediately; after release, first step occurs after PRESCALE enabled cycles.
REQ-039 The bench SHALL cover: direction flip at count=9 in CNT_WRAP, down then up -> 8, then 9, then 0 with a tc pulse.
